// File: rtl/router_fifo.sv
// Router output buffer: one per destination port. Stores bytes tagged with a
// header marker, replays them in order, and gates out_vld with a packet length
// counter loaded from each header so the reader sees one packet's bytes.
// Optional build macro: ROUTER_FIFO_ERR_FLAG_EN adds the sticky err_flag output.
module router_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_reset,
  input  logic              we,
  input  logic              re,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              out_vld,
  output logic              full,
  output logic              empty
`ifdef ROUTER_FIFO_ERR_FLAG_EN
  ,
  output logic              err_flag
`endif
);

  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = DATA_W + 1;
  localparam int unsigned CNT_W   = 7;

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   pkt_cnt;
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic               wr_ok;
  logic               rd_ok;
  logic [ENTRY_W-1:0] rd_entry;
  logic               rd_hdr;
  logic [DATA_W-1:0]  rd_byte;
  logic [CNT_W-1:0]   hdr_len;

  // Occupancy flags from the extra pointer MSB
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign wr_ok    = we & ~full;
  assign rd_ok    = re & ~empty;
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];
  assign rd_hdr   = rd_entry[DATA_W];
  assign rd_byte  = rd_entry[DATA_W-1:0];
  // Header length field counts payload bytes; the parity byte adds one more
  assign hdr_len  = CNT_W'(rd_byte[7:2]) + CNT_W'(1);

  // Storage array; soft_reset only rewinds pointers, contents are kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!soft_reset && wr_ok) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
    end
  end

  // Write and read pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Read data, valid and remaining packet length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      out_vld  <= 1'b0;
      pkt_cnt  <= '0;
    end else if (soft_reset) begin
      data_out <= '0;
      out_vld  <= 1'b0;
      pkt_cnt  <= '0;
    end else if (rd_ok && rd_hdr) begin
      data_out <= rd_byte;
      out_vld  <= 1'b1;
      pkt_cnt  <= hdr_len;
    end else if (rd_ok && (pkt_cnt != '0)) begin
      data_out <= rd_byte;
      out_vld  <= 1'b1;
      pkt_cnt  <= pkt_cnt - CNT_W'(1);
    end else if (pkt_cnt == '0) begin
      // Outside a packet: suppress stray bytes and blank the output
      data_out <= '0;
      out_vld  <= 1'b0;
    end
  end

`ifdef ROUTER_FIFO_ERR_FLAG_EN
  // Sticky overflow/underflow indicator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag <= 1'b0;
    end else if (soft_reset) begin
      err_flag <= 1'b0;
    end else if ((we & full) | (re & empty)) begin
      err_flag <= 1'b1;
    end
  end
`endif

endmodule
